hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/memory-wait
// stall and flush control, a memory-wait timeout FSM and saturating perf counters.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | no outstanding memory wait
// MWAIT | data memory wait in progress, wait_cnt counting stall cycles
// TMO   | wait hit MAX_WAIT; pipeline still held until MemReadyM
module hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic             mem_timeout
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);
  localparam logic [WC_W-1:0] WAIT_SAT  = WC_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    TMO   = 2'd2
  } state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;

  logic mem_stall;
  logic lw_hazard;
  logic sel_mem;
  logic sel_br;
  logic sel_lw;

  assign mem_stall = MemReqM & ~MemReadyM;
  assign lw_hazard = (ResultSrcE == 2'b01) && (rdE != 5'd0) &&
                     ((rdE == rs1) || (rdE == rs2));

  // Priority: memory wait > taken branch > load-use
  assign sel_mem = mem_stall;
  assign sel_br  = ~mem_stall & PCSrcE;
  assign sel_lw  = ~mem_stall & ~PCSrcE & lw_hazard;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteM && (rdM != 5'd0) && (rdM == src))
      sel = 2'b10;
    else if (RegWriteW && (rdW != 5'd0) && (rdW == src))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      if (sel_mem) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (sel_br) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (sel_lw) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (mem_stall) begin
        if (wait_cnt != WAIT_SAT)
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        RUN: begin
          // wait_cnt is 0 here, so this only hits TMO directly when MAX_WAIT is 1
          if (mem_stall) begin
            if (wait_cnt == WAIT_LAST) begin
              state       <= TMO;
              mem_timeout <= 1'b1;
            end else begin
              state <= MWAIT;
            end
          end
        end
        MWAIT: begin
          if (!mem_stall) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= TMO;
            mem_timeout <= 1'b1;
          end
        end
        TMO: begin
          if (!mem_stall)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      lw_stall_cnt  <= '0;
      flush_cnt     <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (sel_lw)
        lw_stall_cnt <= sat_inc(lw_stall_cnt);
      if (sel_br)
        flush_cnt <= sat_inc(flush_cnt);
      if (sel_mem)
        mem_stall_cnt <= sat_inc(mem_stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1, rs2, Rs1E, Rs2E, rdE, rdM, rdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemReqM, MemReadyM, cnt_clr;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] lw_stall_cnt, flush_cnt, mem_stall_cnt;
  logic             mem_timeout;

  int checks = 0;
  int errors = 0;

  // model state
  int m_lw  = 0;
  int m_fl  = 0;
  int m_ms  = 0;
  int m_run = 0;
  bit m_tmo = 1'b0;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs2(rs2), .Rs1E(Rs1E), .Rs2E(Rs2E), .rdE(rdE),
    .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .lw_stall_cnt(lw_stall_cnt), .flush_cnt(flush_cnt),
    .mem_stall_cnt(mem_stall_cnt), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] ctrl_obs;
  assign ctrl_obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                     ForwardAE, ForwardBE};

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_memwait();
    return MemReqM && !MemReadyM;
  endfunction

  function automatic bit is_loaduse();
    return ResultSrcE == 2'b01 && rdE != 0 && (rdE == rs1 || rdE == rs2);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (RegWriteM && rdM != 0 && rdM == src) return 2'b10;
    if (RegWriteW && rdW != 0 && rdW == src) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB}
  function automatic logic [10:0] exp_ctrl();
    logic [3:0] st;
    logic [2:0] fl;
    if (rst) return {4'b0000, 3'b111, 4'b0000};
    if (is_memwait())      begin st = 4'b1111; fl = 3'b001; end
    else if (PCSrcE)       begin st = 4'b0000; fl = 3'b110; end
    else if (is_loaduse()) begin st = 4'b1100; fl = 3'b010; end
    else                   begin st = 4'b0000; fl = 3'b000; end
    return {st, fl, exp_fwd(Rs1E), exp_fwd(Rs2E)};
  endfunction

  function automatic int bump(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task model_edge();
    if (rst) begin
      m_lw = 0; m_fl = 0; m_ms = 0; m_run = 0; m_tmo = 1'b0;
    end else begin
      if (cnt_clr) begin
        m_lw = 0; m_fl = 0; m_ms = 0;
      end else if (is_memwait()) m_ms = bump(m_ms);
      else if (PCSrcE)           m_fl = bump(m_fl);
      else if (is_loaduse())     m_lw = bump(m_lw);
      if (is_memwait()) begin
        m_run++;
        if (m_run >= MAX_WAIT) m_tmo = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Inputs are set by the caller shortly after a rising edge.
  task cycle();
    #2;
    chk("ctrl", 32'(ctrl_obs), 32'(exp_ctrl()));
    chk("lw_stall_cnt", 32'(lw_stall_cnt), m_lw);
    chk("flush_cnt", 32'(flush_cnt), m_fl);
    chk("mem_stall_cnt", 32'(mem_stall_cnt), m_ms);
    chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task idle_inputs();
    rs1 = 0; rs2 = 0; Rs1E = 0; Rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0; cnt_clr = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset outputs and cnt_clr overridden by rst
    cnt_clr = 1;
    cycle();
    chk("rst_flushD", 32'(FlushD), 1);
    cycle();
    rst = 0; cnt_clr = 0;

    // forwarding priority M over W, then W when rdM is x0
    Rs1E = 5; rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1;
    cycle();
    chk("fwdA_M", 32'(ForwardAE), 32'(2'b10));
    rdM = 0;
    cycle();
    chk("fwdA_W", 32'(ForwardAE), 32'(2'b01));
    idle_inputs();

    // load-use stall
    ResultSrcE = 2'b01; rdE = 7; rs2 = 7;
    cycle();
    chk("lu_stallF_flushE", 32'({StallF, StallD, FlushE, FlushD}), 32'(4'b1110));
    chk("lu_cnt", 32'(lw_stall_cnt), 1);

    // branch beats load-use
    PCSrcE = 1;
    cycle();
    chk("br_over_lu", 32'({StallF, StallD, FlushD, FlushE}), 32'(4'b0011));
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_lw_cnt", 32'(lw_stall_cnt), 1);

    // memory wait beats branch for 3 cycles, then branch takes effect
    ResultSrcE = 0; MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mw_hold", 32'({StallM, FlushW, FlushD}), 32'(3'b110));
    end
    MemReadyM = 1;
    cycle();
    chk("mw_release", 32'({FlushD, FlushE, StallF}), 32'(3'b110));
    chk("mw_cnt", 32'(mem_stall_cnt), 3);

    // long wait: timeout after the 15th stall cycle, sticky until rst
    idle_inputs();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == 14) chk("tmo_early", 32'(mem_timeout), 0);
      if (i == 15) chk("tmo_set", 32'(mem_timeout), 1);
    end
    chk("mw_sat", 32'(mem_stall_cnt), CMAX);
    MemReadyM = 1;
    cycle();
    cycle();
    chk("tmo_sticky", 32'(mem_timeout), 1);
    cnt_clr = 1;
    cycle();
    chk("tmo_clr_keep", 32'(mem_timeout), 1);
    cnt_clr = 0;
    rst = 1;
    cycle();
    chk("tmo_rst", 32'(mem_timeout), 0);
    rst = 0;

    // counter saturation and clear with a concurrent increment
    idle_inputs();
    ResultSrcE = 2'b01; rdE = 3; rs1 = 3;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) cycle();
    chk("lw_sat", 32'(lw_stall_cnt), CMAX);
    cnt_clr = 1;
    cycle();
    chk("lw_clr", 32'(lw_stall_cnt), 0);
    cnt_clr = 0;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      cnt_clr    = ($urandom_range(0, 29) == 0);
      rs1        = 5'($urandom_range(0, 3));
      rs2        = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      rdE        = 5'($urandom_range(0, 3));
      rdM        = 5'($urandom_range(0, 3));
      rdW        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      ResultSrcE = 2'($urandom);
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemReqM    = 1'($urandom);
      MemReadyM  = ($urandom_range(0, 4) != 0) || (n >= 200 && n < 240 ? 1'b0 : 1'b0);
      if (n >= 200 && n < 240) begin
        rst = 0; MemReqM = 1; MemReadyM = ($urandom_range(0, 19) == 0);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
